cactus_spawner: RTL and testbench

- Consumes the 5-bit pseudo-random value from the cactus RNG and schedules cactus obstacles for the dino game.
- Runs a gap countdown on each frame tick and spawns cacti at the right screen edge into a fixed pool of slots.
- Scrolls every live slot left by the game speed each tick.
- Feeds the renderer and the collision checker with per-slot valid/x/type.

---
 rtl/cactus_spawner.sv | 172 +++++++++++++++++
 tb/tb_cactus_spawner.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cactus_spawner.sv
// cactus_spawner: schedules cactus obstacles into a fixed slot pool and scrolls them left each frame tick.
// Latency: scroll/free visible 1 clk after tick; a spawn is visible 2 clk after the tick that empties the gap counter.
// Backpressure: none; when every slot is busy at spawn time the attempt is dropped and flagged on spawn_miss.
// Optional build macro CACTUS_SPAWN_STATS_EN adds saturating spawn_count / miss_count outputs.
module cactus_spawner #(
  parameter int NUM_SLOTS = 3,
  parameter int X_W       = 10,
  parameter int SCREEN_W  = 640,
  parameter int MIN_GAP   = 32,
  parameter int GAP_SHIFT = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tick,
  input  logic                   run,
  input  logic                   clr,
  input  logic [4:0]             rand_in,
  input  logic [2:0]             speed,
  output logic [NUM_SLOTS-1:0]   cactus_valid,
  output logic [NUM_SLOTS*X_W-1:0] cactus_x,
  output logic [NUM_SLOTS*2-1:0] cactus_type,
  output logic                   spawn_pulse,
`ifdef CACTUS_SPAWN_STATS_EN
  output logic [15:0]            spawn_count,
  output logic [7:0]             miss_count,
`endif
  output logic                   spawn_miss
);

  // Gap counter must hold the largest reload value MIN_GAP + (31 << GAP_SHIFT).
  localparam int GAP_MAX = MIN_GAP + (31 << GAP_SHIFT);
  localparam int GAP_W   = $clog2(GAP_MAX + 1);
  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(MIN_GAP);
  localparam logic [X_W-1:0]   SPAWN_X  = X_W'(SCREEN_W - 1);

  typedef enum logic {S_WAIT, S_SPAWN} state_t;

  state_t                           state_q;
  logic [GAP_W-1:0]                 gap_q;
  logic                             pulse_q, miss_q;
  logic [NUM_SLOTS-1:0]             valid_q, valid_s, valid_d;
  logic [NUM_SLOTS-1:0][X_W-1:0]    x_q, x_s, x_d;
  logic [NUM_SLOTS-1:0][1:0]        type_q, type_d;
  logic [NUM_SLOTS-1:0]             grant;
  logic                             free_hit;
  logic                             adv;
  logic [GAP_W-1:0]                 gap_reload;

  // A tick only counts while the game is running.
  assign adv        = tick & run;
  assign gap_reload = GAP_INIT + (GAP_W'(rand_in) << GAP_SHIFT);

  // Scroll/free every slot, then allocate the lowest free slot from the post-scroll view.
  always_comb begin
    valid_s  = valid_q;
    x_s      = x_q;
    grant    = '0;
    free_hit = 1'b0;
    if (adv) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        // A slot that would pass the left edge is retired with x frozen, so x never wraps.
        if (x_q[i] < X_W'(speed)) valid_s[i] = 1'b0;
        else                       x_s[i]     = x_q[i] - X_W'(speed);
      end
    end
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!free_hit && !valid_s[i]) begin
        grant[i] = 1'b1;
        free_hit = 1'b1;
      end
    end
    valid_d = valid_s;
    x_d     = x_s;
    type_d  = type_q;
    if (state_q == S_SPAWN) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (grant[i]) begin
          valid_d[i] = 1'b1;
          x_d[i]     = SPAWN_X;
          type_d[i]  = rand_in[1:0];
        end
      end
    end
  end

  // Gap countdown / spawn FSM with registered pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_WAIT;
      gap_q   <= GAP_INIT;
      pulse_q <= 1'b0;
      miss_q  <= 1'b0;
    end else if (clr) begin
      state_q <= S_WAIT;
      gap_q   <= GAP_INIT;
      pulse_q <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      miss_q  <= 1'b0;
      case (state_q)
        S_WAIT: begin
          if (adv) begin
            if (gap_q <= GAP_W'(1)) begin
              gap_q   <= '0;
              state_q <= S_SPAWN;
            end else begin
              gap_q <= gap_q - GAP_W'(1);
            end
          end
        end
        S_SPAWN: begin
          // Completes even with run low; the gap reloads whether or not a slot was free.
          gap_q   <= gap_reload;
          state_q <= S_WAIT;
          pulse_q <= free_hit;
          miss_q  <= ~free_hit;
        end
        default: begin
          state_q <= S_WAIT;
          gap_q   <= GAP_INIT;
        end
      endcase
    end
  end

  // Slot pool state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      x_q     <= '0;
      type_q  <= '0;
    end else if (clr) begin
      valid_q <= '0;
      x_q     <= '0;
      type_q  <= '0;
    end else begin
      valid_q <= valid_d;
      x_q     <= x_d;
      type_q  <= type_d;
    end
  end

`ifdef CACTUS_SPAWN_STATS_EN
  logic [15:0] spawn_cnt_q;
  logic [7:0]  miss_cnt_q;

  // Saturating spawn / miss statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spawn_cnt_q <= '0;
      miss_cnt_q  <= '0;
    end else if (clr) begin
      spawn_cnt_q <= '0;
      miss_cnt_q  <= '0;
    end else if (state_q == S_SPAWN) begin
      if (free_hit && spawn_cnt_q != 16'hFFFF) spawn_cnt_q <= spawn_cnt_q + 16'd1;
      if (!free_hit && miss_cnt_q != 8'hFF)    miss_cnt_q  <= miss_cnt_q + 8'd1;
    end
  end

  assign spawn_count = spawn_cnt_q;
  assign miss_count  = miss_cnt_q;
`endif

  assign cactus_valid = valid_q;
  assign cactus_x     = x_q;
  assign cactus_type  = type_q;
  assign spawn_pulse  = pulse_q;
  assign spawn_miss   = miss_q;

endmodule

// File: tb/tb_cactus_spawner.sv
// tb_cactus_spawner: directed + random stimulus against a slot-pool reference model.
// Each clk the model advances from the sampled inputs and all outputs are compared 1 ns after the edge.
// Gap timing is also measured directly by counting ticks between spawn pulses.
module tb_cactus_spawner;

  logic        clk, rst_n, tick, run, clr;
  logic [4:0]  rand_in;
  logic [2:0]  speed;
  logic [2:0]  cactus_valid;
  logic [29:0] cactus_x;
  logic [5:0]  cactus_type;
  logic        spawn_pulse, spawn_miss;
`ifdef CACTUS_SPAWN_STATS_EN
  logic [15:0] spawn_count;
  logic [7:0]  miss_count;
`endif

  int total = 0;
  int bad   = 0;

  cactus_spawner dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .run(run), .clr(clr),
    .rand_in(rand_in), .speed(speed),
    .cactus_valid(cactus_valid), .cactus_x(cactus_x), .cactus_type(cactus_type),
    .spawn_pulse(spawn_pulse),
`ifdef CACTUS_SPAWN_STATS_EN
    .spawn_count(spawn_count), .miss_count(miss_count),
`endif
    .spawn_miss(spawn_miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: game-level view of the obstacle pool.
  int m_x[3];
  bit m_v[3];
  int m_t[3];
  int m_gap;
  bit m_spawn_due;
  bit m_pulse, m_miss;
  int m_scnt, m_mcnt;

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_x[i] = 0; m_v[i] = 0; m_t[i] = 0;
    end
    m_gap = 32; m_spawn_due = 0; m_pulse = 0; m_miss = 0;
    m_scnt = 0; m_mcnt = 0;
  endfunction

  function automatic void model_step();
    int  slot;
    bit  moving;
    if (clr) begin
      model_reset();
      return;
    end
    moving  = tick && run;
    m_pulse = 0;
    m_miss  = 0;
    if (moving) begin
      for (int i = 0; i < 3; i++) begin
        if (m_x[i] < int'(speed)) m_v[i] = 0;
        else                      m_x[i] = m_x[i] - int'(speed);
      end
    end
    if (m_spawn_due) begin
      slot = -1;
      for (int i = 2; i >= 0; i--) if (!m_v[i]) slot = i;
      if (slot >= 0) begin
        m_v[slot] = 1; m_x[slot] = 639; m_t[slot] = int'(rand_in) % 4;
        m_pulse = 1;
        if (m_scnt < 65535) m_scnt++;
      end else begin
        m_miss = 1;
        if (m_mcnt < 255) m_mcnt++;
      end
      m_gap = 32 + int'(rand_in) * 4;
      m_spawn_due = 0;
    end else if (moving) begin
      m_gap = m_gap - 1;
      if (m_gap == 0) m_spawn_due = 1;
    end
  endfunction

  function automatic logic [2:0] exp_valid();
    logic [2:0] v;
    for (int i = 0; i < 3; i++) v[i] = m_v[i];
    return v;
  endfunction

  function automatic logic [29:0] exp_x();
    logic [29:0] v;
    for (int i = 0; i < 3; i++) v[i*10 +: 10] = 10'(m_x[i]);
    return v;
  endfunction

  function automatic logic [5:0] exp_type();
    logic [5:0] v;
    for (int i = 0; i < 3; i++) v[i*2 +: 2] = 2'(m_t[i]);
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ph);
    check({ph, ":valid"}, 32'(cactus_valid), 32'(exp_valid()));
    check({ph, ":x"},     32'(cactus_x),     32'(exp_x()));
    check({ph, ":type"},  32'(cactus_type),  32'(exp_type()));
    check({ph, ":pulse"}, 32'(spawn_pulse),  32'(m_pulse));
    check({ph, ":miss"},  32'(spawn_miss),   32'(m_miss));
    check({ph, ":excl"},  32'(spawn_pulse & spawn_miss), 32'd0);
`ifdef CACTUS_SPAWN_STATS_EN
    check({ph, ":scnt"},  32'(spawn_count),  32'(m_scnt));
    check({ph, ":mcnt"},  32'(miss_count),   32'(m_mcnt));
`endif
  endtask

  // One clock: model follows the edge, outputs compared 1 ns later.
  task automatic cyc(input string ph);
    @(posedge clk);
    model_step();
    #1;
    check_all(ph);
  endtask

  task automatic step(input bit t, input string ph);
    tick = t;
    cyc(ph);
    tick = 1'b0;
  endtask

  // Ticks every 4 clk until a spawn pulse; returns the tick count.
  task automatic ticks_until_pulse(input string ph, output int n, output bit seen);
    n = 0; seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      for (int k = 0; k < 4; k++) begin
        step(k == 0, ph);
        if (k == 0) n++;
        if (spawn_pulse === 1'b1) seen = 1;
      end
    end
  endtask

  initial begin
    int n;
    bit seen;
    int misses;
    logic [2:0]  snap_v;
    logic [29:0] snap_x;

    rst_n = 1'b0; tick = 1'b0; run = 1'b0; clr = 1'b0; rand_in = 5'd0; speed = 3'd0;
    model_reset();
    #12;
    check("rst:valid", 32'(cactus_valid), 32'd0);
    check("rst:x",     32'(cactus_x),     32'd0);
    check("rst:type",  32'(cactus_type),  32'd0);
    check("rst:pulse", 32'(spawn_pulse),  32'd0);
    check("rst:miss",  32'(spawn_miss),   32'd0);
    #10;
    rst_n = 1'b1;

    // First spawn after 32 ticks, then a 32 + 5*4 = 52 tick gap.
    run = 1'b1; speed = 3'd2; rand_in = 5'd5;
    ticks_until_pulse("first", n, seen);
    check("first_seen", 32'(seen), 32'd1);
    check("first_gap", 32'(n), 32'd32);
    check("first_x0", 32'(cactus_x[9:0]), 32'd639);
    check("first_t0", 32'(cactus_type[1:0]), 32'd1);
    check("first_v", 32'(cactus_valid), 32'b001);
    ticks_until_pulse("second", n, seen);
    check("second_seen", 32'(seen), 32'd1);
    check("second_gap", 32'(n), 32'd52);
    check("second_v", 32'(cactus_valid), 32'b011);

    // Random play: speeds, rand values, sparse ticks, occasional run drop and restart.
    for (int c = 0; c < 3000; c++) begin
      run     = ($urandom_range(0, 9) != 0);
      speed   = 3'($urandom_range(0, 7));
      rand_in = 5'($urandom);
      clr     = ($urandom_range(0, 399) == 0);
      step($urandom_range(0, 2) == 0, "rand");
      clr     = 1'b0;
    end

    // Pool saturation: no motion, so every slot fills and later attempts miss.
    run = 1'b1; speed = 3'd0; rand_in = 5'd0; misses = 0;
    for (int c = 0; c < 250; c++) begin
      step(1'b1, "full");
      if (spawn_miss === 1'b1) misses++;
    end
    check("full_v", 32'(cactus_valid), 32'b111);
    check("full_miss_seen", 32'(misses > 0), 32'd1);

    // Freeze: run low ignores 100 ticks.
    run = 1'b0; speed = 3'd5;
    step(1'b0, "frz"); step(1'b0, "frz");
    snap_v = exp_valid(); snap_x = exp_x();
    for (int c = 0; c < 100; c++) step(1'b1, "frz");
    check("frz_v", 32'(cactus_valid), 32'(snap_v));
    check("frz_x", 32'(cactus_x), 32'(snap_x));

    // Mid-game restart clears everything and restores the 32 tick gap.
    run = 1'b1; speed = 3'd1;
    for (int c = 0; c < 40; c++) step(1'b1, "pre_clr");
    clr = 1'b1; tick = 1'b1;
    cyc("clr");
    clr = 1'b0; tick = 1'b0;
    check("clr_v", 32'(cactus_valid), 32'd0);
    check("clr_x", 32'(cactus_x), 32'd0);
`ifdef CACTUS_SPAWN_STATS_EN
    check("clr_scnt", 32'(spawn_count), 32'd0);
`endif
    speed = 3'd2; rand_in = 5'd9;
    ticks_until_pulse("after_clr", n, seen);
    check("after_clr_seen", 32'(seen), 32'd1);
    check("after_clr_gap", 32'(n), 32'd32);
    check("after_clr_t0", 32'(cactus_type[1:0]), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
